frame_luma_stats: RTL and testbench

//  Per-frame luma statistics stage downstream of the Bayer-to-RGB converter. Consumes the 8-bit

---
 rtl/frame_luma_stats_pkg.sv | 23 ++
 rtl/frame_luma_stats_if.sv | 32 +++
 rtl/frame_luma_stats_div.sv | 80 ++++++++
 rtl/frame_luma_stats.sv | 157 +++++++++++++++
 tb/tb_frame_luma_stats.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/frame_luma_stats_pkg.sv
// Shared types and defaults for the frame luma statistics stage.
// Holds the divider FSM encoding, width defaults and the luma sample type.
package frame_luma_stats_pkg;

    localparam int CNT_W_DEF = 20;
    localparam int SUM_W_DEF = 28;
    localparam int POS_W     = 16;

    typedef logic [7:0] luma_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    function automatic logic [POS_W-1:0] sat_inc_pos(
        input logic [POS_W-1:0] v
    );
        return (&v) ? v : v + POS_W'(1);
    endfunction

endpackage

// File: rtl/frame_luma_stats_if.sv
// Pixel stream in, per-frame statistics out.
// master drives the stream and watches results; slave is the stats stage.
interface frame_luma_stats_if #(
    parameter int CNT_W = 20
);
    import frame_luma_stats_pkg::*;

    logic             VGA_VS;
    logic             iDVAL;
    luma_t            iY;
    luma_t            oMEAN;
    logic             oMEAN_VLD;
    logic [CNT_W-1:0] oPIX_CNT;
    logic             oOVER;
    logic             oUNDER;
    logic             oEMPTY;
    logic             oBUSY;
    logic             oOVERRUN;

    modport master (
        output VGA_VS, iDVAL, iY,
        input  oMEAN, oMEAN_VLD, oPIX_CNT,
        input  oOVER, oUNDER, oEMPTY, oBUSY, oOVERRUN
    );

    modport slave (
        input  VGA_VS, iDVAL, iY,
        output oMEAN, oMEAN_VLD, oPIX_CNT,
        output oOVER, oUNDER, oEMPTY, oBUSY, oOVERRUN
    );

endinterface

// File: rtl/frame_luma_stats_div.sv
// Snapshot registers plus an 8-step restoring divider (sum / cnt).
// A start while busy or done abandons the current divide and reloads.
module luma_mean_div
    import frame_luma_stats_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] sum,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output luma_t            quot,
    output logic [CNT_W-1:0] cnt_out,
    output logic             empty
);

    div_state_t       state;
    div_state_t       state_nx;
    logic [SUM_W-1:0] rem;
    logic [CNT_W-1:0] divisor;
    logic [2:0]       step;
    logic [SUM_W-1:0] trial;

    assign trial   = SUM_W'(divisor) << step;
    assign busy    = (state == ST_DIV);
    assign done    = (state == ST_DONE);
    assign cnt_out = divisor;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a start always wins; empty frames skip the divide.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = (cnt == '0) ? ST_DONE : ST_DIV;
        end else begin
            unique case (state)
                ST_IDLE: state_nx = ST_IDLE;
                ST_DIV:  state_nx = (step == 3'd0) ? ST_DONE : ST_DIV;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Snapshot on start, then one quotient bit per cycle, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            divisor <= '0;
            step    <= 3'd0;
            quot    <= '0;
            empty   <= 1'b0;
        end else if (start) begin
            rem     <= sum;
            divisor <= cnt;
            step    <= 3'd7;
            quot    <= '0;
            empty   <= (cnt == '0);
        end else if (state == ST_DIV) begin
            if (rem >= trial) begin
                rem        <= rem - trial;
                quot[step] <= 1'b1;
            end
            step <= step - 3'd1;
        end
    end

endmodule

// File: rtl/frame_luma_stats.sv
// Per-frame ROI luma statistics: mean, pixel count, exposure flags.
// Tracks pixel position, accumulates over the ROI, divides at frame end.
module frame_luma_stats
    import frame_luma_stats_pkg::*;
#(
    parameter int ROI_X0  = 0,
    parameter int ROI_X1  = 640,
    parameter int ROI_Y0  = 0,
    parameter int ROI_Y1  = 480,
    parameter int LUMA_HI = 200,
    parameter int LUMA_LO = 40,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SUM_W   = SUM_W_DEF
) (
    input  logic                VGA_CLK,
    input  logic                RST,
    frame_luma_stats_if.slave   bus
);

    localparam logic [POS_W-1:0] X0 = POS_W'(ROI_X0);
    localparam logic [POS_W-1:0] X1 = POS_W'(ROI_X1);
    localparam logic [POS_W-1:0] Y0 = POS_W'(ROI_Y0);
    localparam logic [POS_W-1:0] Y1 = POS_W'(ROI_Y1);
    localparam luma_t            HI = luma_t'(LUMA_HI);
    localparam luma_t            LO = luma_t'(LUMA_LO);

    logic             vs_d;
    logic             dval_d;
    logic [POS_W-1:0] x_cnt;
    logic [POS_W-1:0] y_cnt;
    logic             frame_end;
    logic             in_roi;
    logic [SUM_W-1:0] sum;
    logic [SUM_W:0]   sum_add;
    logic [CNT_W-1:0] cnt;

    logic             div_busy;
    logic             div_done;
    luma_t            div_q;
    logic [CNT_W-1:0] div_cnt;
    logic             div_empty;

    luma_t            mean;
    logic [CNT_W-1:0] pix_cnt;
    logic             over;
    logic             under;
    logic             empty;
    logic             vld;
    logic             overrun;

    assign frame_end = vs_d & ~bus.VGA_VS;
    assign in_roi    = bus.iDVAL & bus.VGA_VS
                     & (x_cnt >= X0) & (x_cnt < X1)
                     & (y_cnt >= Y0) & (y_cnt < Y1);
    assign sum_add   = {1'b0, sum} + {{(SUM_W-7){1'b0}}, bus.iY};

    // Delayed strobes for frame-end and line-end edge detection.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            vs_d   <= 1'b0;
            dval_d <= 1'b0;
        end else begin
            vs_d   <= bus.VGA_VS;
            dval_d <= bus.iDVAL;
        end
    end

    // Column counter: zero on the first pixel of each line.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            x_cnt <= '0;
        end else if (bus.iDVAL) begin
            x_cnt <= sat_inc_pos(x_cnt);
        end else begin
            x_cnt <= '0;
        end
    end

    // Line counter: advances at each line end, held at zero between frames.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            y_cnt <= '0;
        end else if (!bus.VGA_VS) begin
            y_cnt <= '0;
        end else if (dval_d && !bus.iDVAL) begin
            y_cnt <= sat_inc_pos(y_cnt);
        end
    end

    // Saturating ROI accumulators, restarted as each frame is handed off.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            sum <= '0;
            cnt <= '0;
        end else if (frame_end) begin
            sum <= '0;
            cnt <= '0;
        end else if (in_roi) begin
            sum <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
            if (!(&cnt)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    luma_mean_div #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_div (
        .clk     (VGA_CLK),
        .rst     (RST),
        .start   (frame_end),
        .sum     (sum),
        .cnt     (cnt),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (div_q),
        .cnt_out (div_cnt),
        .empty   (div_empty)
    );

    // Publish results when a divide completes without being pre-empted.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            mean    <= '0;
            pix_cnt <= '0;
            over    <= 1'b0;
            under   <= 1'b0;
            empty   <= 1'b0;
            vld     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (frame_end && (div_busy || div_done)) begin
                overrun <= 1'b1;
            end
            if (div_done && !frame_end) begin
                mean    <= div_q;
                pix_cnt <= div_cnt;
                over    <= !div_empty && (div_q > HI);
                under   <= !div_empty && (div_q < LO);
                empty   <= div_empty;
                vld     <= 1'b1;
            end
        end
    end

    assign bus.oMEAN     = mean;
    assign bus.oMEAN_VLD = vld;
    assign bus.oPIX_CNT  = pix_cnt;
    assign bus.oOVER     = over;
    assign bus.oUNDER    = under;
    assign bus.oEMPTY    = empty;
    assign bus.oBUSY     = div_busy;
    assign bus.oOVERRUN  = overrun;

endmodule

// File: tb/tb_frame_luma_stats.sv
// Randomised frames against a plain-arithmetic ROI mean model.
// Expected results are queued at frame end and popped on each result pulse.
module tb_frame_luma_stats;
    import frame_luma_stats_pkg::*;

    localparam int X0 = 1;
    localparam int X1 = 9;
    localparam int Y0 = 1;
    localparam int Y1 = 4;
    localparam int HI = 200;
    localparam int LO = 40;
    localparam int CW = 20;
    localparam int SW = 28;

    typedef struct {
        int mean;
        int cnt;
        int over;
        int under;
        int empty;
        int fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    frame_luma_stats_if #(.CNT_W(CW)) bus ();

    frame_luma_stats #(
        .ROI_X0  (X0),
        .ROI_X1  (X1),
        .ROI_Y0  (Y0),
        .ROI_Y1  (Y1),
        .LUMA_HI (HI),
        .LUMA_LO (LO),
        .CNT_W   (CW),
        .SUM_W   (SW)
    ) dut (
        .VGA_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit in_roi(input int x, input int y);
        return x >= X0 && x < X1 && y >= Y0 && y < Y1;
    endfunction

    // Drives one frame; the model sums ROI pixels by position.
    task automatic drive_frame(input int nl, input int minl, input int maxl,
                               input int maxg, input int mode, input int v,
                               output exp_t e);
        int s = 0;
        int c = 0;
        int len;
        int pix;
        bus.VGA_VS = 1'b1;
        for (int y = 0; y < nl; y++) begin
            len = int'($urandom_range(maxl, minl));
            for (int x = 0; x < len; x++) begin
                case (mode)
                    0:       pix = int'($urandom_range(255, 0));
                    1:       pix = v;
                    2:       pix = (v + x > 255) ? 255 : v + x;
                    default: pix = in_roi(x, y) ? v : 255;
                endcase
                bus.iDVAL = 1'b1;
                bus.iY    = 8'(pix);
                if (in_roi(x, y)) begin
                    s += pix;
                    c++;
                end
                @(negedge clk);
            end
            bus.iDVAL = 1'b0;
            bus.iY    = 8'd0;
            repeat ($urandom_range(maxg, 1)) @(negedge clk);
        end
        bus.VGA_VS = 1'b0;
        e.cnt   = c;
        e.empty = (c == 0);
        e.mean  = (c == 0) ? 0 : s / c;
        e.over  = (c != 0) && (e.mean > HI);
        e.under = (c != 0) && (e.mean < LO);
        e.fe    = cyc;
        @(negedge clk);
    endtask

    task automatic frame(input int nl, input int minl, input int maxl,
                         input int mode, input int v);
        exp_t e;
        drive_frame(nl, minl, maxl, 3, mode, v, e);
        sb.push_back(e);
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mean"},    int'(bus.oMEAN),     0);
        chk({tag, "_vld"},     int'(bus.oMEAN_VLD), 0);
        chk({tag, "_pixcnt"},  int'(bus.oPIX_CNT),  0);
        chk({tag, "_over"},    int'(bus.oOVER),     0);
        chk({tag, "_under"},   int'(bus.oUNDER),    0);
        chk({tag, "_empty"},   int'(bus.oEMPTY),    0);
        chk({tag, "_busy"},    int'(bus.oBUSY),     0);
        chk({tag, "_overrun"}, int'(bus.oOVERRUN),  0);
    endtask

    // Monitor: every result pulse must match the oldest queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.oMEAN_VLD === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got pulse at cycle %0d expected none",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("mean",    int'(bus.oMEAN),    e.mean);
                chk("pix_cnt", int'(bus.oPIX_CNT), e.cnt);
                chk("over",    int'(bus.oOVER),    e.over);
                chk("under",   int'(bus.oUNDER),   e.under);
                chk("empty",   int'(bus.oEMPTY),   e.empty);
                chk("latency", cyc - e.fe, (e.empty != 0) ? 2 : 10);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t ea;
        exp_t eb;
        exp_t ec;
        bus.VGA_VS = 1'b0;
        bus.iDVAL  = 1'b0;
        bus.iY     = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        frame(3, 10, 10, 1, 100);
        frame(3, 12, 12, 2, 0);
        frame(4, 10, 12, 1, 255);
        frame(3, 10, 12, 1, 200);
        frame(3, 10, 12, 1, 201);
        frame(3, 10, 12, 1, 40);
        frame(3, 10, 12, 1, 39);
        frame(5, 12, 12, 3, 10);
        frame(1, 3, 12, 0, 0);
        for (int i = 0; i < 20; i++) begin
            frame(int'($urandom_range(5, 1)), 1, 12, 0, 0);
        end

        drive_frame(3, 10, 12, 3, 1, 120, ea);
        drive_frame(2, 2, 2, 1, 1, 77, eb);
        sb.push_back(eb);
        repeat (14) @(negedge clk);
        chk("overrun_set", int'(bus.oOVERRUN), 1);

        drive_frame(3, 10, 12, 3, 1, 90, ec);
        repeat (3) @(negedge clk);
        chk("busy_mid_div", int'(bus.oBUSY), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrst");
        repeat (15) @(negedge clk);

        frame(3, 10, 12, 0, 0);
        frame(4, 8, 12, 1, 150);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("overrun_after_rst", int'(bus.oOVERRUN), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
